// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte streams.
// A grant is held until the owner's last byte or MAX_BURST bytes; the output byte is registered.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic               owner_valid, owner_last;
  logic [7:0]         owner_byte;
  logic               buf_free, accept, burst_done;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Scan from the farthest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_add(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_valid = req_valid_i[i];
        owner_last  = req_last_i[i];
        owner_byte  = req_data_i[8*i +: 8];
      end
    end
  end

  assign grant_o     = (state_q == LOCKED) ? (NUM_REQ'(1) << owner_q) : '0;
  assign buf_free    = ~tx_valid_q | tx_ready_i;
  assign req_ready_o = grant_o & {NUM_REQ{buf_free}};
  assign accept      = (state_q == LOCKED) & owner_valid & buf_free;
  assign burst_done  = (MAX_BURST != 0) && (int'(burst_cnt_q) + 1 == MAX_BURST);
  assign busy_o      = (state_q == LOCKED) | tx_valid_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;

  // NOTE: every signal driven here gets a default first, otherwise an untaken branch infers a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    tx_valid_d  = tx_valid_q & ~tx_ready_i;
    tx_data_d   = tx_data_q;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = LOCKED;
          owner_d     = win_idx;
          burst_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          tx_valid_d = 1'b1;
          tx_data_d  = owner_byte;
          if (MAX_BURST != 0) burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (owner_last || burst_done) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_add(owner_q, 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued message sources per requester and a
// behavioural model of arbitration and the output buffer, compared every cycle.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 tx_valid_o;
  logic [7:0]           tx_data_o;
  logic                 tx_ready_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t src_q [NUM_REQ][$];

  // Reference model: ownership, round-robin pointer, bytes in current grant, output buffer.
  bit         m_locked;
  int         m_owner, m_rr, m_cnt;
  bit         m_txv;
  logic [7:0] m_txd;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_pct, ready_pct;
  int acc_bytes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic reset_model();
    m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_txv = 0; m_txd = 8'h00;
  endtask

  task automatic push_msg(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.data = 8'($urandom);
      b.last = (k == len - 1);
      src_q[r].push_back(b);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        beat_t b;
        b = src_q[i][0];
        req_valid_i[i]       = ($urandom_range(99) < valid_pct);
        req_data_i[8*i +: 8] = b.data;
        req_last_i[i]        = b.last;
      end else begin
        req_valid_i[i]       = 1'b0;
        req_data_i[8*i +: 8] = 8'h00;
        req_last_i[i]        = 1'b0;
      end
    end
    tx_ready_i = ($urandom_range(99) < ready_pct);
  endtask

  // One clock: drive after the edge, compare on the falling edge, then advance the model.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_grant, exp_ready;
    drive_inputs();
    @(negedge clk_i);
    exp_grant = m_locked ? NUM_REQ'(1 << m_owner) : '0;
    exp_ready = (m_locked && (!m_txv || tx_ready_i)) ? exp_grant : '0;
    check("grant", grant_o, exp_grant);
    check("req_ready", req_ready_o, exp_ready);
    check("tx_valid", tx_valid_o, m_txv);
    check("busy", busy_o, m_locked || m_txv);
    if (m_txv) check("tx_data", tx_data_o, m_txd);

    if (!m_locked) begin
      if (m_txv && tx_ready_i) m_txv = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_rr + k) % NUM_REQ;
        if (!m_locked && req_valid_i[idx]) begin
          m_locked = 1; m_owner = idx; m_cnt = 0;
        end
      end
    end else if (req_valid_i[m_owner] && exp_ready[m_owner]) begin
      beat_t b;
      b = src_q[m_owner].pop_front();
      acc_bytes++;
      m_txd = b.data; m_txv = 1; m_cnt++;
      if (b.last || m_cnt == MAX_BURST) begin
        m_locked = 0;
        m_rr = (m_owner + 1) % NUM_REQ;
      end
    end else if (m_txv && tx_ready_i) begin
      m_txv = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      done = !m_locked && !m_txv;
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) done = 0;
      if (!done) cycle();
    end
    check(tag, done, 1);
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_busy", busy_o, 0);
    reset_model();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int start;
    rst_ni = 1'b0; req_valid_i = '0; req_data_i = '0; req_last_i = '0; tx_ready_i = 1'b0;
    reset_model();
    #12 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Three-byte message from req0 with the UART always ready.
    valid_pct = 100; ready_pct = 100;
    src_q[0].push_back('{8'h41, 1'b0});
    src_q[0].push_back('{8'h42, 1'b0});
    src_q[0].push_back('{8'h43, 1'b1});
    drain("drain_t1", 50);

    // Reset after two of five bytes; a fresh arbitration must restart at requester 0.
    push_msg(0, 5);
    start = acc_bytes;
    for (int c = 0; c < 50 && acc_bytes < start + 2; c++) cycle();
    check("t5_two_accepted", acc_bytes - start, 2);
    do_reset();
    push_msg(0, 1);
    push_msg(3, 1);
    drain("drain_t5", 50);

    // Two competing two-byte messages: no interleaving, one bubble between them.
    push_msg(0, 2);
    push_msg(2, 2);
    drain("drain_t2", 50);

    // Backpressure for five cycles mid-stream.
    push_msg(1, 6);
    repeat (4) cycle();
    ready_pct = 0;
    repeat (5) cycle();
    ready_pct = 100;
    drain("drain_t3", 50);

    // 20-byte message forced to release after MAX_BURST, req3 interleaves at the boundary.
    push_msg(1, 20);
    repeat (2) cycle();
    push_msg(3, 1);
    drain("drain_t4", 100);

    // All requesters continuously valid with single-byte messages: order wraps.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) push_msg(i, 1);
    drain("drain_t6", 100);

    // Randomized traffic with random valid gaps and UART stalls.
    valid_pct = 70; ready_pct = 60;
    for (int m = 0; m < 40; m++) push_msg($urandom_range(NUM_REQ - 1), $urandom_range(24, 1));
    drain("drain_rand", 5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
